// File: rtl/polar_8_4_pkg.sv
// Shared constants for the (8,4) polar encoder and BP decoder: code geometry,
// frozen set, information positions and the encoder FSM state type.
package polar_8_4_pkg;

   localparam int unsigned N      = 8;
   localparam int unsigned K      = 4;
   localparam int unsigned STAGES = 3;

   // Bit i set means u[i] is frozen to 0.
   localparam logic [7:0] FROZEN_MASK = 8'b0001_0111;

   // u positions carrying IN_4, IN_6, IN_7, IN_8 in that order.
   localparam int unsigned INFO_POS [K] = '{3, 5, 6, 7};

   localparam int unsigned MAG_DEFAULT = 127;

   // BP iterations run by the matching decoder.
   localparam int unsigned DEC_ITERS = 5;

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StStage,
      StOutput
   } enc_state_e;

   // Scatter info bits {IN_8,IN_7,IN_6,IN_4} onto the unfrozen u positions.
   function automatic logic [N-1:0] place_info(input logic [K-1:0] info);
      logic [N-1:0] u;
      u = '0;
      for (int k = 0; k < K; k++) begin
         u[3'(INFO_POS[k])] = info[2'(k)];
      end
      return u;
   endfunction

endpackage

// File: rtl/polar_enc_8_4_if.sv
// Request/result bundle between a user and the polar encoder.
interface polar_enc_8_4_if
   import polar_8_4_pkg::*;
#(
   parameter int unsigned BIT = 8
);
   logic           start;
   logic           IN_4;
   logic           IN_6;
   logic           IN_7;
   logic           IN_8;
   logic           en_busy;
   logic           done;
   logic [N-1:0]   CW;
   logic [BIT-1:0] LLR_1;
   logic [BIT-1:0] LLR_2;
   logic [BIT-1:0] LLR_3;
   logic [BIT-1:0] LLR_4;
   logic [BIT-1:0] LLR_5;
   logic [BIT-1:0] LLR_6;
   logic [BIT-1:0] LLR_7;
   logic [BIT-1:0] LLR_8;

   modport master (
      output start, IN_4, IN_6, IN_7, IN_8,
      input  en_busy, done, CW,
      input  LLR_1, LLR_2, LLR_3, LLR_4, LLR_5, LLR_6, LLR_7, LLR_8
   );

   modport slave (
      input  start, IN_4, IN_6, IN_7, IN_8,
      output en_busy, done, CW,
      output LLR_1, LLR_2, LLR_3, LLR_4, LLR_5, LLR_6, LLR_7, LLR_8
   );
endinterface

// File: rtl/polar_enc_stage.sv
// One butterfly stage of the polar transform: for each pair (i, i+d) with
// d = 2^stage_i and bit stage_i of i clear, x_i ^= x_(i+d).
module polar_enc_stage
   import polar_8_4_pkg::*;
(
   input  logic [N-1:0] x_i,
   input  logic [1:0]   stage_i,
   output logic [N-1:0] x_o
);

   // Shift the upper partner down onto the lower index and mask to lower slots.
   always_comb begin
      x_o = x_i;
      case (stage_i)
         2'd0:    x_o = x_i ^ ((x_i >> 1) & 8'h55);
         2'd1:    x_o = x_i ^ ((x_i >> 2) & 8'h33);
         2'd2:    x_o = x_i ^ ((x_i >> 4) & 8'h0F);
         default: x_o = x_i;
      endcase
   end

endmodule

// File: rtl/polar_enc_8_4.sv
// (8,4) polar encoder: loads info bits onto u, runs three butterfly stages one
// per clock, then publishes the codeword and its BPSK/LLR mapping.
module polar_enc_8_4
   import polar_8_4_pkg::*;
#(
   parameter int unsigned BIT = 8,
   parameter int unsigned MAG = MAG_DEFAULT
) (
   input logic            clk,
   input logic            rst_n,
   polar_enc_8_4_if.slave bus
);

   localparam logic [BIT-1:0] LLR_POS = BIT'(MAG);
   localparam logic [BIT-1:0] LLR_NEG = ~LLR_POS + 1'b1;

   enc_state_e     state_q;
   logic [1:0]     cnt_q;     // butterfly index currently applied (0..2)
   logic [N-1:0]   x_q;       // holds u at accept, then the in-place transform
   logic [N-1:0]   cw_q;
   logic [BIT-1:0] llr_q [N];
   logic           busy_q;
   logic           done_q;
   logic [N-1:0]   x_stage;

   polar_enc_stage u_stage (
      .x_i     (x_q),
      .stage_i (cnt_q),
      .x_o     (x_stage)
   );

   // Encoder FSM with registered datapath and outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         x_q     <= '0;
         cw_q    <= '0;
         llr_q   <= '{default: '0};
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (bus.start) begin
                  x_q     <= place_info({bus.IN_8, bus.IN_7, bus.IN_6, bus.IN_4});
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= StLoad;
               end
            end
            StLoad: begin
               x_q     <= x_stage;
               cnt_q   <= cnt_q + 2'd1;
               state_q <= StStage;
            end
            StStage: begin
               x_q <= x_stage;
               if (cnt_q == 2'(STAGES - 1)) begin
                  cnt_q   <= '0;
                  state_q <= StOutput;
               end else begin
                  cnt_q <= cnt_q + 2'd1;
               end
            end
            StOutput: begin
               cw_q <= x_q;
               for (int k = 0; k < N; k++) begin
                  llr_q[k] <= x_q[k] ? LLR_NEG : LLR_POS;
               end
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.en_busy = busy_q;
   assign bus.done    = done_q;
   assign bus.CW      = cw_q;
   assign bus.LLR_1   = llr_q[0];
   assign bus.LLR_2   = llr_q[1];
   assign bus.LLR_3   = llr_q[2];
   assign bus.LLR_4   = llr_q[3];
   assign bus.LLR_5   = llr_q[4];
   assign bus.LLR_6   = llr_q[5];
   assign bus.LLR_7   = llr_q[6];
   assign bus.LLR_8   = llr_q[7];

endmodule

// File: tb/tb_polar_enc_8_4.sv
// Scoreboard bench for polar_enc_8_4: stimulus pushes hand-computed codewords,
// a negedge monitor pops and compares whenever done is seen.
module tb_polar_enc_8_4;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;

   polar_enc_8_4_if #(.BIT(8)) bus ();

   polar_enc_8_4 #(
      .BIT (8),
      .MAG (127)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Codeword per pattern p = {IN_8, IN_7, IN_6, IN_4}, built by hand from the
   // basis rows IN_4 -> 0F, IN_6 -> 33, IN_7 -> 55, IN_8 -> FF.
   logic [7:0] cw_tbl [16] = '{
      8'h00, 8'h0F, 8'h33, 8'h3C, 8'h55, 8'h5A, 8'h66, 8'h69,
      8'hFF, 8'hF0, 8'hCC, 8'hC3, 8'hAA, 8'hA5, 8'h99, 8'h96
   };

   logic [7:0] sb_q [$];
   logic [7:0] llr_a [8];

   assign llr_a[0] = bus.LLR_1;
   assign llr_a[1] = bus.LLR_2;
   assign llr_a[2] = bus.LLR_3;
   assign llr_a[3] = bus.LLR_4;
   assign llr_a[4] = bus.LLR_5;
   assign llr_a[5] = bus.LLR_6;
   assign llr_a[6] = bus.LLR_7;
   assign llr_a[7] = bus.LLR_8;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every done pulse is matched against the oldest expected codeword.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus.done === 1'b1) begin
         if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_done: got done=1, expected no pending encode");
         end else begin
            logic [7:0] exp_cw;
            exp_cw = sb_q.pop_front();
            chk("cw", 32'(bus.CW), 32'(exp_cw));
            for (int k = 0; k < 8; k++) begin
               chk($sformatf("llr_%0d", k + 1), 32'(llr_a[k]),
                   exp_cw[k] ? 32'h81 : 32'h7F);
            end
         end
      end
   end

   task automatic drive_info(input logic [3:0] p);
      bus.IN_4 = p[0];
      bus.IN_6 = p[1];
      bus.IN_7 = p[2];
      bus.IN_8 = p[3];
   endtask

   // Called at a negedge with the DUT idle (or in its done cycle). With chain=1
   // it returns in the done cycle so the next call starts back-to-back; with
   // noisy=1 start stays high and info inputs toggle while busy.
   task automatic run_one(input logic [3:0] p, input bit chain, input bit noisy);
      chk("idle_before_start", 32'(bus.en_busy), 32'h0);
      drive_info(p);
      bus.start = 1'b1;
      sb_q.push_back(cw_tbl[p]);
      @(posedge clk);
      @(negedge clk);
      if (!noisy) bus.start = 1'b0;
      for (int c = 0; c < 4; c++) begin
         chk($sformatf("busy_c%0d", c), 32'(bus.en_busy), 32'h1);
         chk($sformatf("no_done_c%0d", c), 32'(bus.done), 32'h0);
         if (noisy) drive_info(4'($urandom_range(0, 15)));
         @(negedge clk);
      end
      chk("done_latency", 32'(bus.done), 32'h1);
      chk("busy_clear", 32'(bus.en_busy), 32'h0);
      bus.start = 1'b0;
      if (!chain) begin
         @(negedge clk);
         chk("done_one_cycle", 32'(bus.done), 32'h0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      n_vec     = 0;
      n_err     = 0;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      drive_info(4'h0);
      #1;
      chk("rst_busy", 32'(bus.en_busy), 32'h0);
      chk("rst_done", 32'(bus.done), 32'h0);
      chk("rst_cw", 32'(bus.CW), 32'h0);
      chk("rst_llr1", 32'(bus.LLR_1), 32'h0);
      chk("rst_llr8", 32'(bus.LLR_8), 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run_one(4'b0000, 1'b0, 1'b0);   // all zero -> 00
      run_one(4'b1000, 1'b0, 1'b0);   // IN_8 -> FF
      run_one(4'b0001, 1'b0, 1'b0);   // IN_4 -> 0F
      run_one(4'b1111, 1'b1, 1'b0);   // all ones -> 96, then back-to-back
      run_one(4'b0010, 1'b0, 1'b0);   // IN_6 -> 33
      run_one(4'b0101, 1'b0, 1'b1);   // start held, inputs toggled -> 5A

      // Abort mid-encode: no done, outputs cleared at once.
      drive_info(4'b1111);
      bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(bus.en_busy), 32'h0);
      chk("abort_done", 32'(bus.done), 32'h0);
      chk("abort_cw", 32'(bus.CW), 32'h0);
      chk("abort_llr1", 32'(bus.LLR_1), 32'h0);
      chk("abort_llr8", 32'(bus.LLR_8), 32'h0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("abort_no_done", 32'(bus.done), 32'h0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      run_one(4'b0011, 1'b0, 1'b0);   // post-reset -> 3C

      // Every pattern, chained back-to-back.
      for (int p = 0; p < 16; p++) begin
         run_one(4'(p), (p != 15), 1'b0);
      end

      @(negedge clk);
      chk("sb_empty", 32'(sb_q.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/polar_enc_8_4.md
Name: polar_enc_8_4

Overview:
- Systematic-position (8,4) polar encoder. It is the transmit-side counterpart of the team's BP (8,4) decoder.
- It places 4 information bits on the unfrozen positions 3,5,6,7 (0-based) and forces frozen positions 0,1,2,4 to 0.
- It runs three butterfly (XOR) stages, one stage per clock, and maps each codeword bit to a BIT-wide BPSK/LLR value.
- The LLR outputs drive the decoder's LLR_1..LLR_8 inputs directly, which enables loopback test.

Parameters:
- BIT, 8, width of each LLR output word (two's complement).
- MAG, 127, LLR magnitude for a mapped bit. Must satisfy MAG <= 2^(BIT-1)-1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request to encode. Sampled only while the block is idle.
- IN_4  input  1  info bit placed at u[3]
- IN_6  input  1  info bit placed at u[5]
- IN_7  input  1  info bit placed at u[6]
- IN_8  input  1  info bit placed at u[7]
- en_busy  output  1  high while an encode is in progress
- done  output  1  one-cycle pulse when CW and the LLR outputs are updated
- CW  output  8  codeword. CW[j] = x_j.
- LLR_1..LLR_8  output  BIT each  mapped codeword. LLR_k corresponds to x_(k-1).

Behaviour:
- Reset: one clock, asynchronous, active-low. State=IDLE, stage counter=0, u register=0, en_busy=0, done=0, CW=0, all LLR_k=0. Reset asserted mid-encode aborts immediately; no done is produced.
- FSM states and transitions:
  - IDLE: on start=1 → LOAD.
  - LOAD: → STAGE.
  - STAGE: repeats for stage counter 1..3, then → OUTPUT.
  - OUTPUT: → IDLE.
- IDLE:
  - en_busy=0.
  - When start=1 at a clock edge: u <= {IN_8,IN_7,IN_6,0,IN_4,0,0,0} (u[7]..u[0]), en_busy <= 1, next state LOAD.
  - Info inputs are sampled only on this edge.
- LOAD and STAGE: one butterfly per edge. Stage s uses span d = 2^(s-1) (s=1,2,3 → d=1,2,4). For every pair (i, i+d) with bit (s-1) of i equal to 0:
  - x_i <= x_i XOR x_(i+d)
  - x_(i+d) <= x_(i+d)
- Result: x = u·F^{⊗3} in natural order (no bit reversal). Equivalently, x_j = XOR of u_i over all i whose bit set contains j's bit set.
- OUTPUT edge:
  - CW <= x.
  - LLR_k <= +MAG if x_(k-1)=0, else -MAG (two's complement, e.g. 8'h81 for MAG=127).
  - done <= 1 for exactly one cycle; en_busy <= 0; return to IDLE.
- Latency: done is high during the cycle following the 4th rising edge after the start-accept edge. The same holds for the LLR update.
- Outputs hold their values until the next OUTPUT edge or reset.
- start while en_busy=1 is ignored; it is neither queued nor able to corrupt the current encode.
- Back-to-back: start=1 in the cycle where done=1 (state IDLE) is accepted. done deasserts on the next edge and the new encode starts without a gap.
- Info inputs changing during busy have no effect.
- Sign convention matches the decoder: sign bit 1 means bit value 1. The frozen value 0 maps to +MAG, the same convention as the decoder's 8'h7F frozen prior.

Decomposition:
- Shared package polar_8_4_pkg, holding:
  - N=8, K=4, STAGES=3
  - FROZEN_MASK=8'b0001_0111
  - information position constants {3,5,6,7}
  - default MAG
  - the decoder iteration count
- The decoder is updated to import the same frozen mask and positions, so encoder and decoder cannot diverge.
- Natural sub-module: polar_enc_stage. It is combinational: 8-bit vector in, stage index in, 8-bit vector out, implementing one butterfly span.
- The top level holds the FSM, the u/x register, the stage counter and the output mapping.

Test Plan:
- All-zero info (IN_4=IN_6=IN_7=IN_8=0), start pulse → done 4 edges after accept; CW=8'h00; all LLR_k=8'h7F; en_busy high for exactly 4 cycles.
- IN_8=1 only → CW=8'hFF; all LLR_k=8'h81.
- IN_4=1 only → CW=8'h0F; LLR_1..4=8'h81, LLR_5..8=8'h7F.
- All info bits 1 → CW=8'h96 (x0..x7 = 0,1,1,0,1,0,0,1); LLR_2,3,5,8=8'h81, others 8'h7F.
  - Then re-assert start in the done cycle with IN_6=1 only → second done exactly 4 edges later with CW=8'h33.
- Robustness: start held high plus random info toggling during busy → result reflects only the values sampled at accept.
  - rst_n pulled low at stage 2 → en_busy=0, done never pulses, CW=0 and LLR=0 immediately; normal encode afterwards.
- Loopback: encoder LLRs feed bp_8_4 for all 16 info patterns → decoder OUT_4/6/7/8 equal IN_4/6/7/8 after the decoder asserts completion.
